// File: rtl/sum_pkg.sv
// Shared types for the summation unit: FSM state encoding and arithmetic mode codes.
package sum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WRAP = 0;
  localparam int SAT  = 1;

endpackage

// File: rtl/sum_adder.sv
// Combinational WIDTH-bit adder with carry out; optionally clamps the result to all-ones on carry.
module sum_adder
  import sum_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SAT_MODE = WRAP
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b};
  assign carry    = full_sum[WIDTH];

  generate
    if (SAT_MODE == SAT) begin : g_sat
      assign result = carry ? {WIDTH{1'b1}} : full_sum[WIDTH-1:0];
    end else begin : g_wrap
      assign result = full_sum[WIDTH-1:0];
    end
  endgenerate

endmodule

// File: rtl/summation_unit.sv
// Accumulates a programmed number of operands over a valid/ready input and pulses done with the final sum.
module summation_unit
  import sum_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 8,
  parameter int SAT_MODE = WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             nill
);

  state_t           state_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             overflow_reg;
  logic [CNT_W-1:0] remaining_reg;

  logic [WIDTH-1:0] add_result;
  logic             add_carry;

  sum_adder #(
    .WIDTH    (WIDTH),
    .SAT_MODE (SAT_MODE)
  ) u_adder (
    .a      (sum_reg),
    .b      (in_data),
    .result (add_result),
    .carry  (add_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      sum_reg       <= '0;
      overflow_reg  <= 1'b0;
      remaining_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            sum_reg       <= '0;
            overflow_reg  <= 1'b0;
            remaining_reg <= count;
            state_reg     <= (count != '0) ? ACC : DONE;
          end
        end
        ACC: begin
          // abort outranks a coincident beat, which is simply dropped
          if (abort) begin
            sum_reg       <= '0;
            overflow_reg  <= 1'b0;
            remaining_reg <= '0;
            state_reg     <= IDLE;
          end else if (in_valid) begin
            sum_reg       <= add_result;
            overflow_reg  <= overflow_reg | add_carry;
            remaining_reg <= remaining_reg - 1'b1;
            if (remaining_reg == CNT_W'(1)) begin
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          if (abort) begin
            sum_reg       <= '0;
            overflow_reg  <= 1'b0;
            remaining_reg <= '0;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Handshake and status flags decode straight from the state register.
  assign in_ready = (state_reg == ACC);
  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
  assign sum      = sum_reg;
  assign overflow = overflow_reg;
  assign nill     = (remaining_reg == '0);

endmodule

// File: tb/tb_summation_unit.sv
// Randomised bench for summation_unit: a wrap and a saturating instance share stimulus and are checked against an integer-total model.
module tb_summation_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] count = '0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;

  logic       in_ready_w, busy_w, done_w, overflow_w, nill_w;
  logic [7:0] sum_w;
  logic       in_ready_s, busy_s, done_s, overflow_s, nill_s;
  logic [7:0] sum_s;

  int total = 0;
  int bad   = 0;
  logic [7:0] dat [16];

  always #5 clk = ~clk;

  summation_unit #(.WIDTH(8), .CNT_W(8), .SAT_MODE(0)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .count(count), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_w), .sum(sum_w),
    .busy(busy_w), .done(done_w), .overflow(overflow_w), .nill(nill_w)
  );

  summation_unit #(.WIDTH(8), .CNT_W(8), .SAT_MODE(1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .count(count), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_s), .sum(sum_s),
    .busy(busy_s), .done(done_s), .overflow(overflow_s), .nill(nill_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({sum_w, busy_w, done_w, in_ready_w, overflow_w, nill_w} !== {8'd0, 5'b00001}) begin
      bad++;
      $display("FAIL reset_wrap: got sum=%0d busy=%b done=%b rdy=%b ovf=%b nill=%b, want 0 0 0 0 0 1",
               sum_w, busy_w, done_w, in_ready_w, overflow_w, nill_w);
    end
    total++;
    if ({sum_s, busy_s, done_s, in_ready_s, overflow_s, nill_s} !== {8'd0, 5'b00001}) begin
      bad++;
      $display("FAIL reset_sat: got sum=%0d busy=%b done=%b rdy=%b ovf=%b nill=%b, want 0 0 0 0 0 1",
               sum_s, busy_s, done_s, in_ready_s, overflow_s, nill_s);
    end
    $display("reset: sum=%0d busy=%b nill=%b", sum_w, busy_w, nill_w);
  endtask

  // One complete operation of n operands from dat[]; vmask bit i gives in_valid on ACC cycle i.
  task automatic test_operation(input string name, input int n, input logic [31:0] vmask,
                                input bit poke_start);
    int acc_total = 0;
    int beats = 0;
    int cyc = 0;
    logic [7:0] exp_w, exp_s;
    logic exp_ovf;
    start = 1'b1;
    count = 8'(n);
    tick();
    start = 1'b0;
    if (n == 0) begin
      total++;
      if (done_w !== 1'b1 || sum_w !== 8'd0 || in_ready_w !== 1'b0 || done_s !== 1'b1) begin
        bad++;
        $display("FAIL %s_empty: done=%b/%b sum=%0d rdy=%b, want done=1/1 sum=0 rdy=0",
                 name, done_w, done_s, sum_w, in_ready_w);
      end
      tick();
      total++;
      if (done_w !== 1'b0 || busy_w !== 1'b0 || sum_w !== 8'd0) begin
        bad++;
        $display("FAIL %s_empty_idle: done=%b busy=%b sum=%0d, want 0 0 0", name, done_w, busy_w, sum_w);
      end
      $display("%s: count=0 sum=%0d", name, sum_w);
      return;
    end
    total++;
    if (busy_w !== 1'b1 || in_ready_w !== 1'b1 || sum_w !== 8'd0 || overflow_w !== 1'b0 || nill_w !== 1'b0) begin
      bad++;
      $display("FAIL %s_start: busy=%b rdy=%b sum=%0d ovf=%b nill=%b, want 1 1 0 0 0",
               name, busy_w, in_ready_w, sum_w, overflow_w, nill_w);
    end
    while (beats < n) begin
      in_valid = (cyc >= 32) ? 1'b1 : vmask[cyc];
      in_data  = dat[beats];
      start    = poke_start && !in_valid;
      count    = 8'd99;
      tick();
      start = 1'b0;
      if (in_valid) begin
        acc_total += int'(dat[beats]);
        beats++;
      end
      in_valid = 1'b0;
      cyc++;
      exp_w   = 8'(acc_total % 256);
      exp_s   = (acc_total > 255) ? 8'd255 : 8'(acc_total);
      exp_ovf = (acc_total > 255);
      total++;
      if (sum_w !== exp_w || sum_s !== exp_s || overflow_w !== exp_ovf || overflow_s !== exp_ovf) begin
        bad++;
        $display("FAIL %s_beat%0d: sum=%0d/%0d ovf=%b/%b, want sum=%0d/%0d ovf=%b",
                 name, beats, sum_w, sum_s, overflow_w, overflow_s, exp_w, exp_s, exp_ovf);
      end
      if (beats < n) begin
        total++;
        if (done_w !== 1'b0 || busy_w !== 1'b1 || in_ready_w !== 1'b1 || nill_w !== 1'b0) begin
          bad++;
          $display("FAIL %s_acc: done=%b busy=%b rdy=%b nill=%b, want 0 1 1 0",
                   name, done_w, busy_w, in_ready_w, nill_w);
        end
      end
    end
    total++;
    if (done_w !== 1'b1 || done_s !== 1'b1 || in_ready_w !== 1'b0 || nill_w !== 1'b1 || busy_w !== 1'b1) begin
      bad++;
      $display("FAIL %s_done: done=%b/%b rdy=%b nill=%b busy=%b, want 1/1 0 1 1",
               name, done_w, done_s, in_ready_w, nill_w, busy_w);
    end
    tick();
    total++;
    if (done_w !== 1'b0 || busy_w !== 1'b0 || sum_w !== exp_w || sum_s !== exp_s || overflow_w !== exp_ovf) begin
      bad++;
      $display("FAIL %s_hold: done=%b busy=%b sum=%0d/%0d ovf=%b, want 0 0 %0d/%0d %b",
               name, done_w, busy_w, sum_w, sum_s, overflow_w, exp_w, exp_s, exp_ovf);
    end
    $display("%s: count=%0d total=%0d sum_wrap=%0d sum_sat=%0d ovf=%b cycles=%0d",
             name, n, acc_total, sum_w, sum_s, overflow_w, cyc);
  endtask

  task automatic test_abort();
    dat[0] = 8'd7; dat[1] = 8'd9;
    start = 1'b1; count = 8'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = dat[i];
      tick();
    end
    abort = 1'b1; in_data = 8'd50;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    total++;
    if (busy_w !== 1'b0 || done_w !== 1'b0 || sum_w !== 8'd0 || overflow_w !== 1'b0 || nill_w !== 1'b1) begin
      bad++;
      $display("FAIL abort_acc: busy=%b done=%b sum=%0d ovf=%b nill=%b, want 0 0 0 0 1",
               busy_w, done_w, sum_w, overflow_w, nill_w);
    end
    tick();
    total++;
    if (done_w !== 1'b0 || sum_w !== 8'd0) begin
      bad++;
      $display("FAIL abort_nodone: done=%b sum=%0d, want 0 0", done_w, sum_w);
    end
    $display("abort_acc: sum=%0d busy=%b", sum_w, busy_w);
    // Abort landing on the DONE cycle clears the result.
    start = 1'b1; count = 8'd1;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 8'd200;
    tick();
    in_valid = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (sum_w !== 8'd0 || busy_w !== 1'b0 || done_w !== 1'b0) begin
      bad++;
      $display("FAIL abort_done: sum=%0d busy=%b done=%b, want 0 0 0", sum_w, busy_w, done_w);
    end
    // Abort while idle leaves the held result alone.
    start = 1'b1; count = 8'd1;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 8'd33;
    tick();
    in_valid = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (sum_w !== 8'd33 || busy_w !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle: sum=%0d busy=%b, want 33 0", sum_w, busy_w);
    end
    $display("abort_idle: sum=%0d", sum_w);
  endtask

  task automatic test_reset_mid_acc();
    start = 1'b1; count = 8'd3;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 8'd77;
    tick();
    rst = 1'b1; abort = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; abort = 1'b0; start = 1'b0; in_valid = 1'b0;
    total++;
    if ({sum_w, busy_w, done_w, in_ready_w, overflow_w, nill_w} !== {8'd0, 5'b00001}) begin
      bad++;
      $display("FAIL reset_mid_acc: sum=%0d busy=%b done=%b rdy=%b ovf=%b nill=%b, want 0 0 0 0 0 1",
               sum_w, busy_w, done_w, in_ready_w, overflow_w, nill_w);
    end
    $display("reset_mid_acc: sum=%0d busy=%b", sum_w, busy_w);
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(0, 8);
      for (int i = 0; i < 16; i++) dat[i] = 8'($urandom_range(0, 255));
      test_operation($sformatf("random%0d", r), n, $urandom, ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 2) == 0) tick();
    end
  endtask

  initial begin
    test_reset();
    dat[0] = 8'd10; dat[1] = 8'd20; dat[2] = 8'd30;
    test_operation("basic", 3, 32'hFFFF_FFFF, 1'b0);
    dat[0] = 8'd200; dat[1] = 8'd100;
    test_operation("wrap", 2, 32'hFFFF_FFFF, 1'b0);
    dat[0] = 8'd1;
    test_operation("ovf_clear", 1, 32'hFFFF_FFFF, 1'b0);
    dat[0] = 8'd200; dat[1] = 8'd100; dat[2] = 8'd5;
    test_operation("saturate", 3, 32'hFFFF_FFFF, 1'b0);
    test_operation("empty", 0, 32'hFFFF_FFFF, 1'b0);
    dat[0] = 8'd1; dat[1] = 8'd2; dat[2] = 8'd3; dat[3] = 8'd4;
    test_operation("gaps", 4, 32'b110101, 1'b1);
    test_abort();
    test_reset_mid_acc();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
